// File: rtl/rename_reg_file_if.sv
// Bundles the read ports, rename, commit, rollback and status signals of rename_reg_file.
// The master side drives requests and the slave side (the register file) answers them.
interface rename_reg_file_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_RD   = 4
);
  logic [NUM_RD*$clog2(NUM_REGS)-1:0] rd_idx_in;
  logic [NUM_RD*XLEN-1:0]             rd_val_out;
  logic [NUM_RD*TAG_W-1:0]            rd_tag_out;
  logic                               alloc_valid_in;
  logic [$clog2(NUM_REGS)-1:0]        alloc_rd_in;
  logic [TAG_W-1:0]                   alloc_tag_in;
  logic                               commit_valid_in;
  logic [$clog2(NUM_REGS)-1:0]        commit_rd_in;
  logic [TAG_W-1:0]                   commit_tag_in;
  logic [XLEN-1:0]                    commit_data_in;
  logic                               rollback_in;
  logic [$clog2(NUM_REGS+1)-1:0]      busy_cnt_out;
  logic [31:0]                        commit_cnt_out;

  modport master (
    output rd_idx_in, alloc_valid_in, alloc_rd_in, alloc_tag_in,
    output commit_valid_in, commit_rd_in, commit_tag_in, commit_data_in, rollback_in,
    input  rd_val_out, rd_tag_out, busy_cnt_out, commit_cnt_out
  );

  modport slave (
    input  rd_idx_in, alloc_valid_in, alloc_rd_in, alloc_tag_in,
    input  commit_valid_in, commit_rd_in, commit_tag_in, commit_data_in, rollback_in,
    output rd_val_out, rd_tag_out, busy_cnt_out, commit_cnt_out
  );
endinterface

// File: rtl/rename_reg_file.sv
// Architectural register file with rename tags: each register holds a value plus a busy
// flag and the ROB tag of its pending producer. Reads are combinational and bypass a
// matching same-cycle commit. Register 0 is hardwired to zero and never renamed.
module rename_reg_file #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_RD   = 4
) (
  input  logic            clk,
  input  logic            rst,
  rename_reg_file_if.slave bus
);
  localparam int IW = $clog2(NUM_REGS);
  localparam int CW = $clog2(NUM_REGS + 1);

  logic [XLEN-1:0]     val_q [NUM_REGS];
  logic [XLEN-1:0]     val_d [NUM_REGS];
  logic [TAG_W-1:0]    tag_q [NUM_REGS];
  logic [TAG_W-1:0]    tag_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [CW-1:0]       busy_cnt_q, busy_cnt_d;
  logic [31:0]         commit_cnt_q;

  logic alloc_ok, commit_ok;
  logic [NUM_RD*XLEN-1:0]  rd_val_flat;
  logic [NUM_RD*TAG_W-1:0] rd_tag_flat;

  // Tag 0 means "no producer", so an alloc carrying it is meaningless and dropped.
  assign alloc_ok  = bus.alloc_valid_in && (bus.alloc_tag_in != '0) && !bus.rollback_in &&
                     (bus.alloc_rd_in != '0);
  assign commit_ok = bus.commit_valid_in && (bus.commit_rd_in != '0);

  // Next-state for every register: commit writes value, rollback > alloc > matching commit.
  always_comb begin
    busy_cnt_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      val_d[r]  = val_q[r];
      busy_d[r] = busy_q[r];
      tag_d[r]  = tag_q[r];
      if (r == 0) begin
        val_d[r]  = '0;
        busy_d[r] = 1'b0;
        tag_d[r]  = '0;
      end else begin
        if (commit_ok && bus.commit_rd_in == IW'(r)) val_d[r] = bus.commit_data_in;
        if (bus.rollback_in) begin
          busy_d[r] = 1'b0;
          tag_d[r]  = '0;
        end else if (alloc_ok && bus.alloc_rd_in == IW'(r)) begin
          busy_d[r] = 1'b1;
          tag_d[r]  = bus.alloc_tag_in;
        end else if (commit_ok && bus.commit_rd_in == IW'(r) && busy_q[r] &&
                     tag_q[r] == bus.commit_tag_in) begin
          busy_d[r] = 1'b0;
          tag_d[r]  = '0;
        end
      end
      busy_cnt_d = busy_cnt_d + CW'(busy_d[r]);
    end
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
      busy_q       <= '0;
      busy_cnt_q   <= '0;
      commit_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        val_q[r] <= val_d[r];
        tag_q[r] <= tag_d[r];
      end
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      // Counts every commit, including those to register 0; wraps naturally.
      if (bus.commit_valid_in) commit_cnt_q <= commit_cnt_q + 32'd1;
    end
  end

  // Read ports: x0 first, then same-cycle commit bypass, then pending tag, then stored value.
  always_comb begin
    logic [IW-1:0] idx;
    rd_val_flat = '0;
    rd_tag_flat = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      idx = bus.rd_idx_in[p*IW +: IW];
      if (idx != '0) begin
        if (busy_q[idx] && bus.commit_valid_in && bus.commit_rd_in == idx &&
            tag_q[idx] == bus.commit_tag_in) begin
          rd_val_flat[p*XLEN +: XLEN] = bus.commit_data_in;
        end else if (busy_q[idx]) begin
          rd_tag_flat[p*TAG_W +: TAG_W] = tag_q[idx];
        end else begin
          rd_val_flat[p*XLEN +: XLEN] = val_q[idx];
        end
      end
    end
  end

  assign bus.rd_val_out     = rd_val_flat;
  assign bus.rd_tag_out     = rd_tag_flat;
  assign bus.busy_cnt_out   = busy_cnt_q;
  assign bus.commit_cnt_out = commit_cnt_q;
endmodule

// File: doc/rename_reg_file.md
RENAME_REG_FILE -- requirements
Module: rename_reg_file

Interface
REQ-001 Parameter XLEN, default 32, data word width.
REQ-002 Parameter NUM_REGS, default 32, architectural register count; index width IW = clog2(NUM_REGS).
REQ-003 Parameter TAG_W, default 4, ROB tag width; tag 0 is the null tag, never allocated.
REQ-004 Parameter NUM_RD, default 4, number of read ports.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 rd_idx_in  input  NUM_RD*IW  flattened read indices, port p at bits [p*IW +: IW].
REQ-008 rd_val_out  output  NUM_RD*XLEN  flattened read values.
REQ-009 rd_tag_out  output  NUM_RD*TAG_W  flattened producer tags; 0 = value valid.
REQ-010 alloc_valid_in  input  1  rename request this cycle.
REQ-011 alloc_rd_in  input  IW  destination register to rename.
REQ-012 alloc_tag_in  input  TAG_W  ROB tag of the renaming instruction.
REQ-013 commit_valid_in  input  1  ROB commit this cycle.
REQ-014 commit_rd_in  input  IW  committed destination register.
REQ-015 commit_tag_in  input  TAG_W  tag of committing entry.
REQ-016 commit_data_in  input  XLEN  committed value.
REQ-017 rollback_in  input  1  flush all speculative renames.
REQ-018 busy_cnt_out  output  clog2(NUM_REGS+1)  registered count of busy registers.
REQ-019 commit_cnt_out  output  32  registered count of accepted commits.

Function
REQ-020 Per register: value[XLEN], busy[1], tag[TAG_W].
REQ-021 Reads are combinational, zero latency; each port independent.
REQ-022 Read priority per port: idx 0 -> value 0, tag 0; else busy and tag==commit_tag_in with commit_valid_in and commit_rd_in==idx -> commit_data_in, tag 0 (commit bypass); else busy -> value 0, tag = stored tag; else stored value, tag 0.
REQ-023 Register 0: never busy, value fixed 0; alloc and commit targeting 0 change nothing.
REQ-024 Commit (commit_valid_in, commit_rd_in!=0): value[rd] <= commit_data_in unconditionally, also during rollback.
REQ-025 Commit clears busy[rd] and sets tag[rd] to 0 only if busy[rd] and tag[rd]==commit_tag_in and no same-cycle alloc to rd.
REQ-026 Alloc (alloc_valid_in, alloc_rd_in!=0, no rollback): busy[rd] <= 1, tag[rd] <= alloc_tag_in, overwriting any prior tag.
REQ-027 Same-cycle alloc and commit to the same register: alloc wins busy/tag; commit still writes value.
REQ-028 Rollback: all busy <= 0, all tags <= 0 next edge; alloc ignored; commit value write per REQ-024 still occurs.
REQ-029 alloc_tag_in == 0 with alloc_valid_in: request ignored.
REQ-030 busy_cnt_out reflects the busy vector after the same edge's update (computed from next-state, registered).
REQ-031 commit_cnt_out increments by 1 per commit_valid_in cycle including rd 0; wraps 2^32-1 -> 0.

Reset
REQ-032 On rst low, immediately: all values 0, busy 0, tags 0, busy_cnt_out 0, commit_cnt_out 0; reads return value 0, tag 0.
REQ-033 Reset asserted mid-operation overrides alloc, commit, rollback; first update after rst rises is the next rising edge.

Verification
REQ-034 Reset, then read x5 on all ports -> value 0, tag 0; busy_cnt_out 0.
REQ-035 Alloc x5 tag 3; next cycle read x5 -> value 0, tag 3; commit x5 tag 3 data 0xDEADBEEF same cycle read -> bypass 0xDEADBEEF tag 0; next cycle stored, busy_cnt 0.
REQ-036 Alloc x7 tag 2, then alloc x7 tag 4, commit x7 tag 2 data 0x11 -> x7 value 0x11 written, still busy tag 4; read shows tag 4.
REQ-037 Same cycle alloc x9 tag 6 and commit x9 tag 5 data 0x22 -> next cycle busy tag 6, value 0x22.
REQ-038 Busy x1,x2,x3 then rollback with commit x4 data 0x33 -> busy_cnt 0, all tags 0, x4 reads 0x33, alloc that cycle dropped.
REQ-039 Alloc/commit to x0 and alloc with tag 0 -> no state change; commit_cnt_out still increments.
